// File: rtl/temp_x10_scaler.sv
// Scales a signed 1/16 degC temperature sample by a constant K using an
// iterative shift-add (one multiplier bit per clock); emits sign + magnitude.
module temp_x10_scaler #(
    parameter int unsigned K  = 10,
    parameter int unsigned KW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] temp_raw,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [16:0] tx10_mag
);

    localparam int unsigned TW = 13;
    localparam int unsigned AW = 17;
    localparam int unsigned CW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [KW-1:0] K_BITS = KW'(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [AW-1:0]   acc, acc_n;
    logic [TW-1:0]   operand, operand_n;
    logic            neg_n;
    logic [AW-1:0]   mag_n;
    logic            busy_n;
    logic            done_n;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            neg      <= 1'b0;
            tx10_mag <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            operand  <= operand_n;
            neg      <= neg_n;
            tx10_mag <= mag_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and datapath; busy/done trail the state by one cycle, so a
    // start is only taken once busy has dropped as well.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        acc_n     = acc;
        operand_n = operand;
        neg_n     = neg;
        mag_n     = tx10_mag;
        busy_n    = (state != IDLE);
        done_n    = (state == DONE);

        case (state)
            IDLE: begin
                if (start && !busy) begin
                    neg_n     = temp_raw[TW-1];
                    operand_n = temp_raw[TW-1] ? TW'(-temp_raw) : temp_raw;
                    acc_n     = '0;
                    cnt_n     = '0;
                    state_n   = MULT;
                end
            end
            MULT: begin
                if (K_BITS[cnt]) begin
                    acc_n = acc + (AW'(operand) << cnt);
                end
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(KW - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                mag_n   = acc;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_temp_x10_scaler.sv
// Scoreboard bench for temp_x10_scaler: directed starts push expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_temp_x10_scaler;

    localparam int PERIOD = 10;
    localparam int LAT    = 5;

    typedef struct {
        logic        neg;
        logic [16:0] mag;
        time         t_start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] temp_raw;
    logic        busy;
    logic        done;
    logic        neg;
    logic [16:0] tx10_mag;

    exp_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   pushed   = 0;
    int   done_cnt = 0;

    temp_x10_scaler #(.K(10), .KW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .temp_raw (temp_raw),
        .busy     (busy),
        .done     (done),
        .neg      (neg),
        .tx10_mag (tx10_mag)
    );

    always #(PERIOD / 2) clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("neg", longint'(neg), longint'(e.neg));
                check("tx10_mag", longint'(tx10_mag), longint'(e.mag));
                check("latency", longint'($time - e.t_start),
                      longint'(LAT * PERIOD + PERIOD / 2));
            end
        end
    end

    // Drive one start pulse; the accepting edge is timestamped for latency
    task automatic issue(input logic [12:0] t, input logic en, input logic exp_neg,
                         input logic [16:0] exp_mag);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        temp_raw = t;
        @(posedge clk);
        if (en) begin
            e.neg     = exp_neg;
            e.mag     = exp_mag;
            e.t_start = $time;
            q.push_back(e);
            pushed++;
        end
        #1 start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_neg"}, longint'(neg), 0);
        check({tag, "_mag"}, longint'(tx10_mag), 0);
    endtask

    logic [12:0] vec_in [6] = '{13'd400, 13'd394, 13'h1E76, 13'h1000, 13'h0FFF, 13'd0};
    logic        vec_neg[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [16:0] vec_mag[6] = '{17'h00FA0, 17'h00F64, 17'h00F64, 17'h0A000, 17'h09FF6, 17'h00000};

    initial begin
        int busy_cycles;
        rst      = 1'b1;
        start    = 1'b0;
        temp_raw = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Directed vectors, each run to completion
        for (int i = 0; i < 6; i++) begin
            issue(vec_in[i], 1'b1, vec_neg[i], vec_mag[i]);
            repeat (8) @(negedge clk);
        end

        // Second start during MULT is dropped; busy lasts exactly LAT cycles
        issue(13'd400, 1'b1, 1'b0, 17'h00FA0);
        busy_cycles = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) check("hold_prev_mag", longint'(tx10_mag), 0);
            if (busy) busy_cycles++;
            start    = (i == 1);
            temp_raw = (i == 1) ? 13'd100 : 13'd0;
        end
        start = 1'b0;
        check("busy_cycles", longint'(busy_cycles), LAT);
        repeat (3) @(negedge clk);

        // Reset in the second MULT cycle abandons the operation
        issue(13'd394, 1'b0, 1'b0, 17'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        issue(13'd400, 1'b1, 1'b0, 17'h00FA0);
        repeat (10) @(negedge clk);

        check("pending_results", longint'(q.size()), 0);
        check("done_pulses", longint'(done_cnt), longint'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #(PERIOD * 5000);
        $display("FAIL timeout: simulation reached %0t, expected completion earlier", $time);
        $fatal(1);
    end

endmodule
